// File: rtl/control_pkg.sv
// Shared opcodes, T-state indices and control-word layout for the bus-CPU control sequencer.
package control_pkg;

  localparam int unsigned StepW = 3;
  localparam int unsigned OpW   = 4;

  localparam logic [OpW-1:0] OP_NOP = 4'h0;
  localparam logic [OpW-1:0] OP_LDA = 4'h1;
  localparam logic [OpW-1:0] OP_ADD = 4'h2;
  localparam logic [OpW-1:0] OP_SUB = 4'h3;
  localparam logic [OpW-1:0] OP_STA = 4'h4;
  localparam logic [OpW-1:0] OP_LDI = 4'h5;
  localparam logic [OpW-1:0] OP_JMP = 4'h6;
  localparam logic [OpW-1:0] OP_JC  = 4'h7;
  localparam logic [OpW-1:0] OP_JZ  = 4'h8;
  localparam logic [OpW-1:0] OP_OUT = 4'hE;
  localparam logic [OpW-1:0] OP_HLT = 4'hF;

  localparam logic [StepW-1:0] T0 = 3'd0;
  localparam logic [StepW-1:0] T1 = 3'd1;
  localparam logic [StepW-1:0] T2 = 3'd2;
  localparam logic [StepW-1:0] T3 = 3'd3;
  localparam logic [StepW-1:0] T4 = 3'd4;

  // Fields hold the pin-level value, so _n fields are active-low.
  typedef struct packed {
    logic pc_count_enable;
    logic pc_jump_n;
    logic pc_write_bus;
    logic mar_read_bus_n;
    logic ram_read_bus_n;
    logic ram_write_bus_n;
    logic ir_read_bus_n;
    logic ir_write_bus_n;
    logic a_read_bus_n;
    logic a_write_bus_n;
    logic b_read_bus_n;
    logic alu_write_bus_n;
    logic alu_subtract;
    logic flags_read_n;
    logic out_read_bus;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '{
    pc_count_enable: 1'b0,
    pc_jump_n:       1'b1,
    pc_write_bus:    1'b0,
    mar_read_bus_n:  1'b1,
    ram_read_bus_n:  1'b1,
    ram_write_bus_n: 1'b1,
    ir_read_bus_n:   1'b1,
    ir_write_bus_n:  1'b1,
    a_read_bus_n:    1'b1,
    a_write_bus_n:   1'b1,
    b_read_bus_n:    1'b1,
    alu_write_bus_n: 1'b1,
    alu_subtract:    1'b0,
    flags_read_n:    1'b1,
    out_read_bus:    1'b0
  };

  // Last T-state carrying any execute activity; jumps end at T2 whether taken or not.
  function automatic logic [StepW-1:0] last_exec_step(input logic [OpW-1:0] op);
    case (op)
      OP_LDA, OP_STA:         return T3;
      OP_ADD, OP_SUB, OP_HLT: return T4;
      default:                return T2;
    endcase
  endfunction

endpackage

// File: rtl/control_microcode.sv
// Combinational microcode ROM: {step, opcode, flags} -> control word.
module control_microcode
  import control_pkg::*;
(
  input  logic [StepW-1:0] step_i,
  input  logic [OpW-1:0]   opcode_i,
  input  logic             flag_carry_i,
  input  logic             flag_zero_i,
  output ctrl_word_t       ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (step_i)
      T0: begin
        ctrl_o.pc_write_bus   = 1'b1;
        ctrl_o.mar_read_bus_n = 1'b0;
      end
      T1: begin
        ctrl_o.ram_write_bus_n = 1'b0;
        ctrl_o.ir_read_bus_n   = 1'b0;
        ctrl_o.pc_count_enable = 1'b1;
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl_o.ir_write_bus_n = 1'b0;
            ctrl_o.mar_read_bus_n = 1'b0;
          end
          OP_LDI: begin
            ctrl_o.ir_write_bus_n = 1'b0;
            ctrl_o.a_read_bus_n   = 1'b0;
          end
          OP_JMP: begin
            ctrl_o.ir_write_bus_n = 1'b0;
            ctrl_o.pc_jump_n      = 1'b0;
          end
          OP_JC: begin
            ctrl_o.ir_write_bus_n = !flag_carry_i;
            ctrl_o.pc_jump_n      = !flag_carry_i;
          end
          OP_JZ: begin
            ctrl_o.ir_write_bus_n = !flag_zero_i;
            ctrl_o.pc_jump_n      = !flag_zero_i;
          end
          OP_OUT: begin
            ctrl_o.a_write_bus_n = 1'b0;
            ctrl_o.out_read_bus  = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            ctrl_o.ram_write_bus_n = 1'b0;
            ctrl_o.a_read_bus_n    = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            ctrl_o.ram_write_bus_n = 1'b0;
            ctrl_o.b_read_bus_n    = 1'b0;
            ctrl_o.alu_subtract    = (opcode_i == OP_SUB);
          end
          OP_STA: begin
            ctrl_o.a_write_bus_n  = 1'b0;
            ctrl_o.ram_read_bus_n = 1'b0;
          end
          default: ;
        endcase
      end
      T4: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ctrl_o.alu_write_bus_n = 1'b0;
          ctrl_o.a_read_bus_n    = 1'b0;
          ctrl_o.flags_read_n    = 1'b0;
          ctrl_o.alu_subtract    = (opcode_i == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-state counter, halt latch and reset gating around the microcode ROM.
// Define XDN_CONTROL_EARLY_RETIRE_EN to return to T0 right after an instruction's last active step.
module control_sequencer
  import control_pkg::*;
#(
  parameter int unsigned STEP_WIDTH   = 3,
  parameter int unsigned LAST_STEP    = 4,
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input  logic                    i_CLOCK,
  input  logic                    i_CLEAR,
  input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
  input  logic                    i_FLAG_CARRY,
  input  logic                    i_FLAG_ZERO,
  output logic                    o_PC_COUNT_ENABLE,
  output logic                    o_PC_JUMP_n,
  output logic                    o_PC_WRITE_BUS,
  output logic                    o_MAR_READ_BUS_n,
  output logic                    o_RAM_READ_BUS_n,
  output logic                    o_RAM_WRITE_BUS_n,
  output logic                    o_IR_READ_BUS_n,
  output logic                    o_IR_WRITE_BUS_n,
  output logic                    o_A_READ_BUS_n,
  output logic                    o_A_WRITE_BUS_n,
  output logic                    o_B_READ_BUS_n,
  output logic                    o_ALU_WRITE_BUS_n,
  output logic                    o_ALU_SUBTRACT,
  output logic                    o_FLAGS_READ_n,
  output logic                    o_OUT_READ_BUS,
  output logic                    o_CLOCK_HALT,
  output logic [STEP_WIDTH-1:0]   o_STEP
);

  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  halted_q, halted_d;
  logic                  halt_now;
  logic                  wrap;
  ctrl_word_t            ctrl_rom, ctrl;

  control_microcode u_microcode (
    .step_i       (step_q),
    .opcode_i     (i_OPCODE),
    .flag_carry_i (i_FLAG_CARRY),
    .flag_zero_i  (i_FLAG_ZERO),
    .ctrl_o       (ctrl_rom)
  );

  assign halt_now = (step_q == T2) && (i_OPCODE == OP_HLT);

`ifdef XDN_CONTROL_EARLY_RETIRE_EN
  assign wrap = (step_q == STEP_WIDTH'(LAST_STEP)) ||
                ((step_q >= T2) && (step_q == last_exec_step(i_OPCODE)));
`else
  assign wrap = (step_q == STEP_WIDTH'(LAST_STEP));
`endif

  always_comb begin
    halted_d = halted_q | halt_now;
    step_d   = step_q;
    if (!halted_q && !halt_now) begin
      step_d = wrap ? '0 : step_q + 1'b1;
    end
  end

  always_ff @(posedge i_CLOCK or posedge i_CLEAR) begin
    if (i_CLEAR) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // While halted the opcode may wander; keep every control line quiet.
  always_comb begin
    ctrl = ctrl_rom;
    if (i_CLEAR || halted_q) begin
      ctrl = CTRL_IDLE;
    end
  end

  assign o_PC_COUNT_ENABLE = ctrl.pc_count_enable;
  assign o_PC_JUMP_n       = ctrl.pc_jump_n;
  assign o_PC_WRITE_BUS    = ctrl.pc_write_bus;
  assign o_MAR_READ_BUS_n  = ctrl.mar_read_bus_n;
  assign o_RAM_READ_BUS_n  = ctrl.ram_read_bus_n;
  assign o_RAM_WRITE_BUS_n = ctrl.ram_write_bus_n;
  assign o_IR_READ_BUS_n   = ctrl.ir_read_bus_n;
  assign o_IR_WRITE_BUS_n  = ctrl.ir_write_bus_n;
  assign o_A_READ_BUS_n    = ctrl.a_read_bus_n;
  assign o_A_WRITE_BUS_n   = ctrl.a_write_bus_n;
  assign o_B_READ_BUS_n    = ctrl.b_read_bus_n;
  assign o_ALU_WRITE_BUS_n = ctrl.alu_write_bus_n;
  assign o_ALU_SUBTRACT    = ctrl.alu_subtract;
  assign o_FLAGS_READ_n    = ctrl.flags_read_n;
  assign o_OUT_READ_BUS    = ctrl.out_read_bus;
  assign o_CLOCK_HALT      = !i_CLEAR && (halted_q || halt_now);
  assign o_STEP            = i_CLEAR ? '0 : step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven and scoreboard bench for control_sequencer; honours XDN_CONTROL_EARLY_RETIRE_EN.
module tb_control_sequencer;

  // Activity mask: bit set means the line is asserted, whatever its pin polarity.
  localparam int M_PCE  = 0;
  localparam int M_JMP  = 1;
  localparam int M_PCW  = 2;
  localparam int M_MAR  = 3;
  localparam int M_RAMR = 4;
  localparam int M_RAMW = 5;
  localparam int M_IRR  = 6;
  localparam int M_IRW  = 7;
  localparam int M_AR   = 8;
  localparam int M_AW   = 9;
  localparam int M_BR   = 10;
  localparam int M_ALUW = 11;
  localparam int M_SUB  = 12;
  localparam int M_FLG  = 13;
  localparam int M_OUT  = 14;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] op  = 4'h0;
  logic       cy  = 1'b0;
  logic       zf  = 1'b0;
  logic o_pce, o_jmp_n, o_pcw, o_mar_n, o_ramr_n, o_ramw_n, o_irr_n, o_irw_n;
  logic o_ar_n, o_aw_n, o_br_n, o_aluw_n, o_sub, o_flg_n, o_out, o_halt;
  logic [2:0] o_step;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .i_CLOCK           (clk),
    .i_CLEAR           (clr),
    .i_OPCODE          (op),
    .i_FLAG_CARRY      (cy),
    .i_FLAG_ZERO       (zf),
    .o_PC_COUNT_ENABLE (o_pce),
    .o_PC_JUMP_n       (o_jmp_n),
    .o_PC_WRITE_BUS    (o_pcw),
    .o_MAR_READ_BUS_n  (o_mar_n),
    .o_RAM_READ_BUS_n  (o_ramr_n),
    .o_RAM_WRITE_BUS_n (o_ramw_n),
    .o_IR_READ_BUS_n   (o_irr_n),
    .o_IR_WRITE_BUS_n  (o_irw_n),
    .o_A_READ_BUS_n    (o_ar_n),
    .o_A_WRITE_BUS_n   (o_aw_n),
    .o_B_READ_BUS_n    (o_br_n),
    .o_ALU_WRITE_BUS_n (o_aluw_n),
    .o_ALU_SUBTRACT    (o_sub),
    .o_FLAGS_READ_n    (o_flg_n),
    .o_OUT_READ_BUS    (o_out),
    .o_CLOCK_HALT      (o_halt),
    .o_STEP            (o_step)
  );

  typedef struct {
    string       tag;
    int          step;
    logic [14:0] mask;
    logic        halt;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [3:0]  op;
    logic        cy;
    logic        zf;
    int          step;
    logic [14:0] mask;
    logic        halt;
  } vec_t;

  function automatic logic [14:0] dut_mask();
    return {o_out, !o_flg_n, o_sub, !o_aluw_n, !o_br_n, !o_aw_n, !o_ar_n, !o_irw_n,
            !o_irr_n, !o_ramw_n, !o_ramr_n, !o_mar_n, o_pcw, !o_jmp_n, o_pce};
  endfunction

  function automatic logic [14:0] bit1(input int b);
    logic [14:0] m;
    m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  // Reference model of the microcode, in activity-mask form.
  function automatic logic [14:0] model(input int st, input logic [3:0] o, input logic c,
                                        input logic z);
    logic [14:0] m;
    m = '0;
    if (st == 0) m = bit1(M_PCW) | bit1(M_MAR);
    else if (st == 1) m = bit1(M_RAMW) | bit1(M_IRR) | bit1(M_PCE);
    else if (st == 2) begin
      if (o inside {4'h1, 4'h2, 4'h3, 4'h4}) m = bit1(M_IRW) | bit1(M_MAR);
      else if (o == 4'h5) m = bit1(M_IRW) | bit1(M_AR);
      else if (o == 4'h6 || (o == 4'h7 && c) || (o == 4'h8 && z)) m = bit1(M_IRW) | bit1(M_JMP);
      else if (o == 4'hE) m = bit1(M_AW) | bit1(M_OUT);
    end else if (st == 3) begin
      if (o == 4'h1) m = bit1(M_RAMW) | bit1(M_AR);
      else if (o == 4'h2 || o == 4'h3) m = bit1(M_RAMW) | bit1(M_BR);
      else if (o == 4'h4) m = bit1(M_AW) | bit1(M_RAMR);
      if (o == 4'h3) m[M_SUB] = 1'b1;
    end else if (st == 4) begin
      if (o == 4'h2 || o == 4'h3) m = bit1(M_ALUW) | bit1(M_AR) | bit1(M_FLG);
      if (o == 4'h3) m[M_SUB] = 1'b1;
    end
    return m;
  endfunction

  function automatic int next_step(input int st, input logic [3:0] o);
    int last;
    last = 4;
`ifdef XDN_CONTROL_EARLY_RETIRE_EN
    if (o == 4'h1 || o == 4'h4) last = 3;
    else if (o != 4'h2 && o != 4'h3) last = 2;
`endif
    if (st >= 2 && st == last) return 0;
    return (st == 4) ? 0 : st + 1;
  endfunction

  task automatic push(input string tag, input int st, input logic [14:0] m, input logic h);
    exp_t e;
    e.tag = tag; e.step = st; e.mask = m; e.halt = h;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if (dut_mask() !== e.mask || int'(o_step) != e.step || o_halt !== e.halt) begin
      errors++;
      $display("FAIL %s: got mask=%h step=%0d halt=%b, want mask=%h step=%0d halt=%b",
               e.tag, dut_mask(), o_step, o_halt, e.mask, e.step, e.halt);
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[18];

  initial begin
    logic [14:0] fetch;
    fetch = bit1(M_PCW) | bit1(M_MAR) | bit1(M_RAMW) | bit1(M_IRR) | bit1(M_PCE);

    vecs[0]  = '{4'h0, 0, 0, 0, bit1(M_PCW) | bit1(M_MAR), 0};
    vecs[1]  = '{4'h0, 0, 0, 1, bit1(M_RAMW) | bit1(M_IRR) | bit1(M_PCE), 0};
    vecs[2]  = '{4'h1, 0, 0, 2, bit1(M_IRW) | bit1(M_MAR), 0};
    vecs[3]  = '{4'h1, 0, 0, 3, bit1(M_RAMW) | bit1(M_AR), 0};
    vecs[4]  = '{4'h2, 0, 0, 3, bit1(M_RAMW) | bit1(M_BR), 0};
    vecs[5]  = '{4'h2, 0, 0, 4, bit1(M_ALUW) | bit1(M_AR) | bit1(M_FLG), 0};
    vecs[6]  = '{4'h3, 0, 0, 3, bit1(M_RAMW) | bit1(M_BR) | bit1(M_SUB), 0};
    vecs[7]  = '{4'h3, 0, 0, 4, bit1(M_ALUW) | bit1(M_AR) | bit1(M_FLG) | bit1(M_SUB), 0};
    vecs[8]  = '{4'h4, 0, 0, 3, bit1(M_AW) | bit1(M_RAMR), 0};
    vecs[9]  = '{4'h5, 0, 0, 2, bit1(M_IRW) | bit1(M_AR), 0};
    vecs[10] = '{4'h6, 0, 0, 2, bit1(M_IRW) | bit1(M_JMP), 0};
    vecs[11] = '{4'h7, 0, 1, 2, 15'h0, 0};
    vecs[12] = '{4'h7, 1, 0, 2, bit1(M_IRW) | bit1(M_JMP), 0};
    vecs[13] = '{4'h8, 1, 0, 2, 15'h0, 0};
    vecs[14] = '{4'h8, 0, 1, 2, bit1(M_IRW) | bit1(M_JMP), 0};
    vecs[15] = '{4'hE, 0, 0, 2, bit1(M_AW) | bit1(M_OUT), 0};
    vecs[16] = '{4'hF, 0, 0, 2, 15'h0, 1};
    vecs[17] = '{4'h9, 1, 1, 2, 15'h0, 0};

    // Reset state: everything idle while clear is held.
    #2;
    push("reset_idle", 0, 15'h0, 1'b0);
    pop_check();

    for (int i = 0; i < 18; i++) begin
      op = vecs[i].op; cy = vecs[i].cy; zf = vecs[i].zf;
      do_reset();
      repeat (vecs[i].step) tick();
      push($sformatf("vec%0d_op%h_t%0d", i, vecs[i].op, vecs[i].step), vecs[i].step,
           vecs[i].mask, vecs[i].halt);
      pop_check();
    end

    // Clear asserted mid-T3 of LDI aborts at once, then fetch restarts at T0.
    op = 4'h5; cy = 0; zf = 0;
    do_reset();
    repeat (3) tick();
    @(negedge clk);
    clr = 1'b1;
    #1;
    push("clear_mid_t3", 0, 15'h0, 1'b0);
    pop_check();
    @(negedge clk);
    clr = 1'b0;
    #1;
    push("after_clear_t0", 0, bit1(M_PCW) | bit1(M_MAR), 1'b0);
    pop_check();

    // HLT: halt asserts at T2, step freezes for 10 clocks, only clear exits.
    op = 4'hF;
    do_reset();
    repeat (2) tick();
    push("hlt_t2", 2, 15'h0, 1'b1);
    pop_check();
    repeat (10) tick();
    push("hlt_frozen", 2, 15'h0, 1'b1);
    pop_check();
    op = 4'h5;
    #1;
    push("hlt_opcode_change", 2, 15'h0, 1'b1);
    pop_check();
    do_reset();
    push("hlt_cleared", 0, bit1(M_PCW) | bit1(M_MAR), 1'b0);
    pop_check();

    // Step sequences per opcode, tracked by the model, including wrap back to T0.
    for (int o = 0; o < 16; o++) begin
      for (int f = 0; f < 4; f++) begin
        int st;
        op = 4'(o); cy = f[0]; zf = f[1];
        do_reset();
        st = 0;
        for (int k = 0; k < 6; k++) begin
          logic [14:0] m;
          int nbus;
          push($sformatf("seq_op%h_f%0d_k%0d", o, f, k), st, model(st, op, cy, zf),
               (o == 15 && st == 2));
          pop_check();
          m = dut_mask();
          nbus = int'(m[M_PCW]) + int'(m[M_RAMW]) + int'(m[M_IRW]) + int'(m[M_AW]) +
                 int'(m[M_ALUW]);
          checks++;
          if (nbus > 1) begin
            errors++;
            $display("FAIL bus_drivers op%h t%0d: got %0d drivers, want at most 1", o, st, nbus);
          end
          if (o >= 9 && o <= 13) begin
            checks++;
            if ((m & ~fetch) != 15'h0) begin
              errors++;
              $display("FAIL undef_fetch_only op%h t%0d: got mask=%h, want only fetch bits",
                       o, st, m);
            end
          end
          if (o == 15 && st == 2) break;
          // Flags toggled after T2 must not disturb the rest of the instruction.
          if (st == 2) begin
            @(negedge clk);
            cy = ~cy; zf = ~zf;
          end
          tick();
          st = next_step(st, op);
        end
      end
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
